// File: rtl/zeroriscy_ex_sequencer.sv
// Issue/sequencing controller between ID and the execute units: one op in flight,
// unit enables held until ready, with flush, timeout and illegal-op abort plus an ID stall counter.
module zeroriscy_ex_sequencer #(
  parameter int RV32M          = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [1:0]           op_class_i,
  input  logic                 flush_i,
  output logic                 mult_en_o,
  output logic                 div_en_o,
  output logic                 lsu_en_o,
  input  logic                 multdiv_ready_i,
  input  logic                 lsu_ready_i,
  output logic                 ex_valid_o,
  output logic                 busy_o,
  output logic                 err_o,
  input  logic                 stall_clr_i,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_ALU  = 2'd0;
  localparam logic [1:0] OP_MULT = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;

  typedef enum logic [1:0] {IDLE, MULDIV, LSU, LSU_KILL} state_e;

  typedef struct packed {
    logic mult_en;
    logic div_en;
    logic lsu_en;
    logic ex_valid;
    logic err;
  } ex_out_t;

  state_e         state_q, state_d;
  ex_out_t        out_q, out_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0] stall_q;

  logic accept, tmo_hit;

  assign id_ready_o = (state_q == IDLE) & ~flush_i;
  assign accept     = id_valid_i & id_ready_o;
  assign tmo_hit    = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    out_d            = out_q;
    out_d.ex_valid   = 1'b0;
    out_d.err        = 1'b0;
    tmo_d            = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tmo_d = '0;
          unique case (op_class_i)
            OP_ALU: out_d.ex_valid = 1'b1;
            OP_MULT, OP_DIV: begin
              if (RV32M != 0) begin
                state_d       = MULDIV;
                out_d.mult_en = (op_class_i == OP_MULT);
                out_d.div_en  = (op_class_i == OP_DIV);
              end else begin
                out_d.err = 1'b1;
              end
            end
            default: begin
              state_d      = LSU;
              out_d.lsu_en = 1'b1;
            end
          endcase
        end
      end
      MULDIV: begin
        // flush beats ready, ready beats timeout
        if (flush_i || multdiv_ready_i || tmo_hit) begin
          state_d        = IDLE;
          out_d.mult_en  = 1'b0;
          out_d.div_en   = 1'b0;
          out_d.ex_valid = ~flush_i & multdiv_ready_i;
          out_d.err      = ~flush_i & ~multdiv_ready_i;
        end
      end
      LSU: begin
        if (lsu_ready_i) begin
          state_d        = IDLE;
          out_d.lsu_en   = 1'b0;
          out_d.ex_valid = ~flush_i;
        end else if (tmo_hit) begin
          state_d      = IDLE;
          out_d.lsu_en = 1'b0;
          out_d.err    = 1'b1;
        end else if (flush_i) begin
          // LSU access cannot be cancelled; keep the enable and drain silently
          state_d = LSU_KILL;
        end
      end
      default: begin
        if (lsu_ready_i) begin
          state_d      = IDLE;
          out_d.lsu_en = 1'b0;
        end else if (tmo_hit) begin
          state_d      = IDLE;
          out_d.lsu_en = 1'b0;
          out_d.err    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (stall_clr_i)
      stall_q <= '0;
    else if (id_valid_i && !id_ready_o && !(&stall_q))
      stall_q <= stall_q + 1'b1;
  end

  assign mult_en_o   = out_q.mult_en;
  assign div_en_o    = out_q.div_en;
  assign lsu_en_o    = out_q.lsu_en;
  assign ex_valid_o  = out_q.ex_valid;
  assign err_o       = out_q.err;
  assign busy_o      = (state_q != IDLE);
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_zeroriscy_ex_sequencer.sv
// Directed bench for zeroriscy_ex_sequencer: main instance (RV32M=1, T=64, CNT=16),
// short-timeout instance (T=4, CNT=4) and an RV32M=0 instance, all on shared stimulus.
module tb_zeroriscy_ex_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, flush, multdiv_ready, lsu_ready, stall_clr;
  logic [1:0] op_class;

  logic a_id_ready, a_mult_en, a_div_en, a_lsu_en, a_ex_valid, a_busy, a_err;
  logic t_id_ready, t_mult_en, t_div_en, t_lsu_en, t_ex_valid, t_busy, t_err;
  logic n_id_ready, n_mult_en, n_div_en, n_lsu_en, n_ex_valid, n_busy, n_err;
  logic [15:0] a_stall, n_stall;
  logic [3:0]  t_stall;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  zeroriscy_ex_sequencer #(.RV32M(1), .TIMEOUT_CYCLES(64), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_ready_o(a_id_ready),
    .op_class_i(op_class), .flush_i(flush), .mult_en_o(a_mult_en), .div_en_o(a_div_en),
    .lsu_en_o(a_lsu_en), .multdiv_ready_i(multdiv_ready), .lsu_ready_i(lsu_ready),
    .ex_valid_o(a_ex_valid), .busy_o(a_busy), .err_o(a_err),
    .stall_clr_i(stall_clr), .stall_cnt_o(a_stall));

  zeroriscy_ex_sequencer #(.RV32M(1), .TIMEOUT_CYCLES(4), .CNT_WIDTH(4)) dut_t (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_ready_o(t_id_ready),
    .op_class_i(op_class), .flush_i(flush), .mult_en_o(t_mult_en), .div_en_o(t_div_en),
    .lsu_en_o(t_lsu_en), .multdiv_ready_i(multdiv_ready), .lsu_ready_i(lsu_ready),
    .ex_valid_o(t_ex_valid), .busy_o(t_busy), .err_o(t_err),
    .stall_clr_i(stall_clr), .stall_cnt_o(t_stall));

  zeroriscy_ex_sequencer #(.RV32M(0), .TIMEOUT_CYCLES(64), .CNT_WIDTH(16)) dut_n (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_ready_o(n_id_ready),
    .op_class_i(op_class), .flush_i(flush), .mult_en_o(n_mult_en), .div_en_o(n_div_en),
    .lsu_en_o(n_lsu_en), .multdiv_ready_i(multdiv_ready), .lsu_ready_i(lsu_ready),
    .ex_valid_o(n_ex_valid), .busy_o(n_busy), .err_o(n_err),
    .stall_clr_i(stall_clr), .stall_cnt_o(n_stall));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    id_valid = 0; flush = 0; multdiv_ready = 0; lsu_ready = 0; stall_clr = 0; op_class = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick;
  endtask

  // present op for one cycle; returns one cycle after acceptance
  task automatic issue(input logic [1:0] op);
    id_valid = 1; op_class = op;
    tick;
    id_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    // reset state
    id_valid = 0; flush = 0; multdiv_ready = 0; lsu_ready = 0; stall_clr = 0; op_class = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_ready", a_id_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_enables", {a_mult_en, a_div_en, a_lsu_en}, 0);
    chk("rst_ex_valid", a_ex_valid, 0);
    chk("rst_err", a_err, 0);
    chk("rst_stall", a_stall, 0);
    flush = 1; #1;
    chk("rst_flush_ready", a_id_ready, 0);
    flush = 0;
    rst = 0;
    tick;

    // ALU: single-cycle completion, never busy
    chk("alu_ready_pre", a_id_ready, 1);
    issue(2'd0);
    chk("alu_ex_valid", a_ex_valid, 1);
    chk("alu_busy", a_busy, 0);
    chk("alu_ready_post", a_id_ready, 1);
    tick;
    chk("alu_ex_valid_once", a_ex_valid, 0);

    // DIV: enable cycles 1..36, result at 37
    issue(2'd2);
    for (int k = 1; k <= 36; k++) begin
      chk("div_en", a_div_en, 1);
      chk("div_mult_en", a_mult_en, 0);
      chk("div_id_ready", a_id_ready, 0);
      chk("div_ex_valid_early", a_ex_valid, 0);
      if (k == 36) multdiv_ready = 1;
      tick;
    end
    multdiv_ready = 0;
    chk("div_ex_valid", a_ex_valid, 1);
    chk("div_en_off", a_div_en, 0);
    chk("div_busy_off", a_busy, 0);
    chk("div_id_ready_back", a_id_ready, 1);
    tick;
    chk("div_ex_valid_once", a_ex_valid, 0);

    // MULT: flush and ready together -> flush wins
    issue(2'd1);
    chk("mul_en", a_mult_en, 1);
    chk("mul_busy", a_busy, 1);
    flush = 1; multdiv_ready = 1;
    tick;
    chk("mulfl_ex_valid", a_ex_valid, 0);
    chk("mulfl_en_off", a_mult_en, 0);
    chk("mulfl_busy", a_busy, 0);
    chk("mulfl_ready_flush", a_id_ready, 0);
    flush = 0; multdiv_ready = 0; #1;
    chk("mulfl_ready", a_id_ready, 1);
    tick;
    chk("mulfl_no_late_valid", a_ex_valid, 0);

    // LSU normal completion
    issue(2'd3);
    chk("lsu_en", a_lsu_en, 1);
    lsu_ready = 1;
    tick;
    lsu_ready = 0;
    chk("lsu_ex_valid", a_ex_valid, 1);
    chk("lsu_en_off", a_lsu_en, 0);
    chk("lsu_busy", a_busy, 0);

    // LSU flush and ready together -> done, no write-back
    issue(2'd3);
    flush = 1; lsu_ready = 1;
    tick;
    flush = 0; lsu_ready = 0;
    chk("lsufr_ex_valid", a_ex_valid, 0);
    chk("lsufr_en_off", a_lsu_en, 0);
    chk("lsufr_busy", a_busy, 0);

    // LSU flush at cycle 3, ready at 8: enable held through 8, silent drain
    issue(2'd3);
    for (int c = 1; c <= 8; c++) begin
      chk("lsukill_en", a_lsu_en, 1);
      chk("lsukill_ex_valid", a_ex_valid, 0);
      chk("lsukill_busy", a_busy, 1);
      if (c == 3) flush = 1;
      if (c == 6) flush = 0;
      if (c == 8) lsu_ready = 1;
      tick;
    end
    lsu_ready = 0;
    chk("lsukill_en_off", a_lsu_en, 0);
    chk("lsukill_idle", a_busy, 0);
    chk("lsukill_no_valid", a_ex_valid, 0);
    tick;
    chk("lsukill_no_valid2", a_ex_valid, 0);

    // reset mid-operation
    issue(2'd1);
    tick;
    rst = 1; #1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_en", a_mult_en, 0);
    chk("midrst_ready", a_id_ready, 1);
    multdiv_ready = 1;
    tick;
    rst = 0;
    tick;
    chk("midrst_no_valid", a_ex_valid, 0);
    chk("midrst_no_err", a_err, 0);
    multdiv_ready = 0;

    // timeout T=4: enable cycles 1..4, err at 5, exactly once
    do_reset;
    issue(2'd1);
    for (int c = 1; c <= 4; c++) begin
      chk("tmo_en", t_mult_en, 1);
      chk("tmo_err_early", t_err, 0);
      tick;
    end
    chk("tmo_err", t_err, 1);
    chk("tmo_ex_valid", t_ex_valid, 0);
    chk("tmo_en_off", t_mult_en, 0);
    chk("tmo_busy", t_busy, 0);
    errs = 0;
    repeat (5) begin
      tick;
      errs += int'(t_err);
      chk("tmo_en_stays_off", t_mult_en, 0);
    end
    chk("tmo_err_once", errs, 0);

    // ready on the timeout cycle -> ready wins
    do_reset;
    issue(2'd1);
    repeat (3) tick;
    multdiv_ready = 1;
    tick;
    multdiv_ready = 0;
    chk("tmordy_ex_valid", t_ex_valid, 1);
    chk("tmordy_err", t_err, 0);

    // flush on the timeout cycle -> flush wins, no err
    issue(2'd2);
    repeat (3) tick;
    flush = 1;
    tick;
    flush = 0;
    chk("tmofl_err", t_err, 0);
    chk("tmofl_ex_valid", t_ex_valid, 0);
    chk("tmofl_busy", t_busy, 0);
    chk("tmofl_div_en", t_div_en, 0);

    // stall counter: exact count, saturation at 15, clear priority
    do_reset;
    id_valid = 1; op_class = 2'd1;
    repeat (5) tick;
    chk("stall_t_4", t_stall, 4);
    repeat (25) tick;
    chk("stall_t_sat", t_stall, 15);
    chk("stall_a_29", a_stall, 29);
    stall_clr = 1;
    tick;
    chk("stall_t_clr", t_stall, 0);
    chk("stall_a_clr", a_stall, 0);
    stall_clr = 0; id_valid = 0;

    // RV32M=0: DIV/MULT abort with err, no enable
    do_reset;
    issue(2'd2);
    chk("nom_div_err", n_err, 1);
    chk("nom_div_en", n_div_en, 0);
    chk("nom_div_busy", n_busy, 0);
    chk("nom_div_ex_valid", n_ex_valid, 0);
    tick;
    chk("nom_err_once", n_err, 0);
    issue(2'd1);
    chk("nom_mul_err", n_err, 1);
    chk("nom_mul_en", n_mult_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
